// File: rtl/sram_ws_model.sv
// External-SRAM model with req/ack handshake, byte lanes, programmable wait states,
// request abort and out-of-range error reporting. The array is not cleared by reset.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | waiting for req; captures addr/we/be/wdata on req=1
// ST_WAIT | counting down wait states; req=0 aborts back to idle
// ST_ACK  | one-cycle completion; write commits on the edge leaving
module sram_ws_model #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 18,
    parameter int DEPTH       = 4096,
    parameter int WAIT_STATES = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      req,
    input  logic                      we,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic [DATA_WIDTH/8-1:0]   be,
    input  logic [DATA_WIDTH-1:0]     wdata,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic                      ack,
    output logic                      err,
    output logic                      busy
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]    WS_L    = CNT_W'(WAIT_STATES);
    localparam logic [CNT_W-1:0]    CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    we_q, we_d;
    logic [LANES-1:0]        be_q, be_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic                    cur_we;
    logic                    cur_in_range;
    logic [IDX_W-1:0]        cur_idx;
    logic                    addr_ok;
    logic [IDX_W-1:0]        wr_idx;

    // With zero wait states the access goes IDLE->ACK directly, so the read
    // must use the live bus fields instead of the not-yet-latched copies.
    always_comb begin
        cur_addr     = (state_q == ST_IDLE) ? addr : addr_q;
        cur_we       = (state_q == ST_IDLE) ? we   : we_q;
        cur_in_range = ({1'b0, cur_addr} < DEPTH_L);
        cur_idx      = cur_addr[IDX_W-1:0];
        addr_ok      = ({1'b0, addr_q} < DEPTH_L);
        wr_idx       = addr_q[IDX_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    addr_d  = addr;
                    we_d    = we;
                    be_d    = be;
                    wdata_d = wdata;
                    if (WAIT_STATES > 0) begin
                        cnt_d   = WS_L;
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_ONE) begin
                    cnt_d   = '0;
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        // rdata is loaded on the edge entering ACK; write acks leave it unchanged.
        if ((state_d == ST_ACK) && (state_q != ST_ACK) && !cur_we) begin
            rdata_d = cur_in_range ? mem[cur_idx] : '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Array has no reset: contents must survive reset_n pulses.
    always_ff @(posedge clk) begin
        if ((state_q == ST_ACK) && we_q && addr_ok) begin
            for (int i = 0; i < LANES; i++) begin
                if (be_q[i]) begin
                    mem[wr_idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign ack   = (state_q == ST_ACK);
    assign err   = (state_q == ST_ACK) && !addr_ok;
    assign busy  = (state_q != ST_IDLE);
    assign rdata = rdata_q;

endmodule
